// File: rtl/sha256_multiblock_core.sv
// SHA-256 / SHA-256d core hashing NUM_BLOCKS pre-padded 512-bit blocks, one round per clock.
// Define SHA_BYTE_SWAP_EN to present the digest fully byte-reversed (Bitcoin display order).
module sha256_multiblock_core #(
    parameter int NUM_BLOCKS  = 2,
    parameter int DOUBLE_HASH = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [512*NUM_BLOCKS-1:0] message,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [255:0]              digest,
    output logic                      busy
);

    localparam int MSG_W = 512 * NUM_BLOCKS;
    localparam int BLK_W = $clog2(NUM_BLOCKS) + 1;
    localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(NUM_BLOCKS - 1);

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, DONE} state_t;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_s0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_s1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

`ifdef SHA_BYTE_SWAP_EN
    function automatic logic [255:0] present(input logic [255:0] x);
        for (int i = 0; i < 32; i++) present[8*i +: 8] = x[255-8*i -: 8];
    endfunction
`else
    function automatic logic [255:0] present(input logic [255:0] x);
        return x;
    endfunction
`endif

    state_t           state;
    logic [MSG_W-1:0] msg_q;      // current block always sits in the top 512 bits
    logic [31:0]      hv [8];     // chaining value H0..H7
    logic [31:0]      wv [8];     // working variables a..h
    logic [31:0]      w  [16];    // sliding schedule window, w[0] = W[t]
    logic [5:0]       rnd;
    logic [BLK_W-1:0] blk;
    logic             pass2;

    logic [31:0]  t1, t2, w_next;
    logic [31:0]  hnew [8];
    logic [255:0] hnew_flat;
    logic [511:0] cur_block;

    always_comb begin
        cur_block = msg_q[MSG_W-1 -: 512];
        t1 = wv[7] + big_s1(wv[4]) + ((wv[4] & wv[5]) ^ (~wv[4] & wv[6])) + K[rnd] + w[0];
        t2 = big_s0(wv[0]) + ((wv[0] & wv[1]) ^ (wv[0] & wv[2]) ^ (wv[1] & wv[2]));
        w_next = small_s1(w[14]) + w[9] + small_s0(w[1]) + w[0];
        hnew_flat = '0;
        for (int i = 0; i < 8; i++) begin
            hnew[i] = hv[i] + wv[i];
            hnew_flat[255-32*i -: 32] = hnew[i];
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            digest    <= '0;
            msg_q     <= '0;
            rnd       <= '0;
            blk       <= '0;
            pass2     <= 1'b0;
            hv        <= IV;
            // NOTE: the schedule window is ordinary flops, so it is cleared here to leave no residue after an abort.
            for (int i = 0; i < 8; i++)  wv[i] <= '0;
            for (int i = 0; i < 16; i++) w[i]  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        msg_q    <= message;
                        hv       <= IV;
                        blk      <= '0;
                        pass2    <= 1'b0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    for (int i = 0; i < 16; i++) w[i] <= cur_block[511-32*i -: 32];
                    wv    <= hv;
                    rnd   <= '0;
                    state <= ROUND;
                end
                ROUND: begin
                    wv[0] <= t1 + t2;
                    wv[1] <= wv[0];
                    wv[2] <= wv[1];
                    wv[3] <= wv[2];
                    wv[4] <= wv[3] + t1;
                    wv[5] <= wv[4];
                    wv[6] <= wv[5];
                    wv[7] <= wv[6];
                    for (int i = 0; i < 15; i++) w[i] <= w[i+1];
                    w[15] <= w_next;
                    rnd   <= rnd + 6'd1;
                    if (rnd == 6'd63) state <= FINAL;
                end
                FINAL: begin
                    if (!pass2 && blk != LAST_BLK) begin
                        hv    <= hnew;
                        blk   <= blk + 1'b1;
                        msg_q <= msg_q << 512;
                        state <= LOAD;
                    end else if (!pass2 && DOUBLE_HASH != 0) begin
                        // second pass hashes the 32-byte first digest as a single padded block
                        hv    <= IV;
                        pass2 <= 1'b1;
                        msg_q[MSG_W-1 -: 512] <= {hnew_flat, 32'h80000000, 192'h0, 32'h00000100};
                        state <= LOAD;
                    end else begin
                        hv        <= hnew;
                        digest    <= present(hnew_flat);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/sha256_multiblock_core.md
SHA256_MULTIBLOCK_CORE -- requirements
Module: sha256_multiblock_core

Interface
- REQ-001 SHALL have parameter NUM_BLOCKS, default 2: count of pre-padded 512-bit blocks per message; legal range 1..8.
- REQ-002 SHALL have parameter DOUBLE_HASH, default 1: 1 = rehash the first digest once more (SHA-256d), 0 = single SHA-256.
- REQ-003 SHALL have port clk, input, 1: the single clock; all state on rising edge.
- REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
- REQ-005 SHALL have port in_valid, input, 1: message is valid.
- REQ-006 SHALL have port in_ready, output, 1: core accepts a message.
- REQ-007 SHALL have port message, input, 512*NUM_BLOCKS: pre-padded message; block 0 sits in the MSBs and each block is big-endian word 0 first.
- REQ-008 SHALL have port out_valid, output, 1: digest is valid.
- REQ-009 SHALL have port out_ready, input, 1: consumer takes the digest.
- REQ-010 SHALL have port digest, output, 256: result, with word A in the MSBs.
- REQ-011 SHALL have port busy, output, 1: high in every state except IDLE.

Function
- REQ-012 SHALL implement states IDLE, LOAD, ROUND, FINAL and DONE.
- REQ-013 SHALL assert in_ready only in IDLE, and SHALL capture message into an internal register on in_valid && in_ready, then go to LOAD.
- REQ-014 LOAD SHALL take one cycle: load the 16-word schedule window from the current block, set working vars a..h from the chaining value H, and clear the round counter.
- REQ-015 ROUND SHALL execute one SHA-256 round per cycle for t=0..63, using K[t] from an internal constant ROM.
- REQ-016 ROUND SHALL take W[t] from the window for t<16 and shift in W[t]=s1(W[t-2])+W[t-7]+s0(W[t-15])+W[t-16] for t>=16, with all sums mod 2^32.
- REQ-017 FINAL SHALL take one cycle: H <= H + {a..h} per word, mod 2^32.
- REQ-018 After FINAL, if blocks remain in the first pass, the FSM SHALL go to LOAD with the next block.
- REQ-019 After the last first-pass block with DOUBLE_HASH=1, the FSM SHALL go to LOAD with block {H, 32'h80000000, 6 zero words, 32'h00000100} and SHALL reset H to the initial value.
- REQ-020 Otherwise the FSM SHALL latch digest and go to DONE.
- REQ-021 The initial H SHALL be 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19.
- REQ-022 Latency SHALL be: with input handshake at edge k, out_valid rises after edge k + 66*(NUM_BLOCKS+DOUBLE_HASH). Default: 198 cycles.
- REQ-023 DONE SHALL hold out_valid and a stable digest until out_ready; on that handshake the FSM SHALL return to IDLE, and out_valid SHALL drop the next cycle.
- REQ-024 in_valid outside IDLE SHALL be ignored; message changes after capture SHALL have no effect.
- REQ-025 The block counter SHALL be $clog2(NUM_BLOCKS)+1 bits wide and SHALL never wrap within one message.
- REQ-026 Any input handshake SHALL take at least 1 cycle after out handshake, because in_ready is low in DONE.

Reset
- REQ-027 rst SHALL force IDLE immediately, regardless of clock, including mid-ROUND or in DONE.
- REQ-028 Under rst, in_ready SHALL be 1 and out_valid, busy and digest SHALL be 0; H, a..h, W and counters SHALL be 0 or initial values.
- REQ-029 After rst releases, the first in_valid SHALL start a clean hash with no residue from the aborted one.

Configuration
- REQ-030 Macro SHA_BYTE_SWAP_EN, when defined, SHALL present digest fully byte-reversed (Bitcoin display order; byte 0 of A becomes digest[7:0]).
- REQ-031 Without SHA_BYTE_SWAP_EN, digest SHALL be big-endian {A..H}.
- REQ-032 Latency SHALL be identical with and without SHA_BYTE_SWAP_EN.

Verification
- REQ-033 NUM_BLOCKS=1, DOUBLE_HASH=0, "abc" padded -> digest ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad at exactly cycle 66.
- REQ-034 NUM_BLOCKS=1, DOUBLE_HASH=1, empty-string padded block -> digest 5df6e0e2761359d30a8275058e299fcc0381534545f55cf43e41983f5d4c9456 at cycle 132.
- REQ-035 Defaults, SHA_BYTE_SWAP_EN defined, Bitcoin genesis 80-byte header padded to 1024 bits -> digest 000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f at cycle 198.
- REQ-036 out_ready held low 50 cycles after out_valid -> out_valid and digest stable throughout; in_ready low; IDLE 1 cycle after out_ready.
- REQ-037 rst pulsed at round 30 of block 1, then "abc" test rerun -> reset outputs seen asynchronously, then correct abc digest.
- REQ-038 in_valid toggled and message changed during ROUND -> ignored; digest matches the originally captured message.
